// File: rtl/fp32_mul.sv
// Pipelined IEEE-754 binary32 multiplier (out = in1 * in2), round-to-nearest-even,
// gradual underflow, canonical qNaN. Operands are captured, multiplied, then normalised/rounded/packed.
module fp32_mul #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out,
    output logic        out_valid,
    output logic        flag_invalid,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    typedef enum logic [1:0] {CLS_NUM, CLS_NAN, CLS_INF, CLS_ZERO} cls_e;

    typedef struct packed {
        logic               sign;
        cls_e               cls;
        logic               inv;
        logic signed [11:0] exp;
        logic [47:0]        prod;
    } s1_t;

    logic [LATENCY:0] vld_pipe;
    logic [31:0]      a_q, b_q;
    s1_t              s1_d, s1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s1_q     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LATENCY-1:0], in_valid};
            a_q      <= in1;
            b_q      <= in2;
            s1_q     <= s1_d;
        end
    end

    // Stage 1: classify, form significands, multiply, sum exponents
    logic [7:0]  ea, eb, ea_eff, eb_eff;
    logic [22:0] fa, fb;
    logic [23:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign fa     = a_q[22:0];
    assign fb     = b_q[22:0];
    assign ma     = {(ea != 8'd0), fa};
    assign mb     = {(eb != 8'd0), fb};
    assign ea_eff = (ea == 8'd0) ? 8'd1 : ea;
    assign eb_eff = (eb == 8'd0) ? 8'd1 : eb;
    assign a_zero = (ea == 8'd0) && (fa == 23'd0);
    assign b_zero = (eb == 8'd0) && (fb == 23'd0);
    assign a_inf  = (ea == 8'hff) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hff) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hff) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hff) && (fb != 23'd0);
    assign a_snan = a_nan && !fa[22];
    assign b_snan = b_nan && !fb[22];

    always_comb begin
        s1_d      = '0;
        s1_d.sign = a_q[31] ^ b_q[31];
        s1_d.prod = {24'd0, ma} * {24'd0, mb};
        s1_d.exp  = $signed({4'd0, ea_eff}) + $signed({4'd0, eb_eff}) - 12'sd127;
        s1_d.cls  = CLS_NUM;
        if (a_nan || b_nan) begin
            s1_d.cls = CLS_NAN;
            s1_d.inv = a_snan || b_snan;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            s1_d.cls = CLS_NAN;
            s1_d.inv = 1'b1;
        end else if (a_inf || b_inf) begin
            s1_d.cls = CLS_INF;
        end else if (a_zero || b_zero) begin
            s1_d.cls = CLS_ZERO;
        end
    end

    function automatic logic [5:0] lzc48(input logic [47:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 48; i++)
            if (v[i]) n = 6'(47 - i);
        return n;
    endfunction

    // Stage 2: normalise, denormalise, round, pack
    logic [5:0]         lz, sh;
    logic [47:0]        norm, mask, m;
    logic signed [11:0] e, dsh, ef;
    logic               tiny_pre, tiny, lost, g, r, st, up, inexact, ovf;
    logic [24:0]        rnd;
    logic [31:0]        res;
    logic [3:0]         flags;

    always_comb begin
        lz       = lzc48(s1_q.prod);
        norm     = s1_q.prod << lz;
        e        = s1_q.exp + 12'sd1 - $signed({6'd0, lz});
        tiny_pre = (e < 12'sd1);
        dsh      = 12'sd1 - e;
        sh       = 6'd0;
        if (tiny_pre)
            sh = (dsh > 12'sd48) ? 6'd48 : dsh[5:0];
        mask     = (sh == 6'd48) ? '1 : ((48'd1 << sh) - 48'd1);
        lost     = |(norm & mask);
        m        = norm >> sh;
        g        = m[23];
        r        = m[22];
        st       = (|m[21:0]) | lost;
        up       = g & (r | st | m[24]);
        rnd      = {1'b0, m[47:24]} + {24'd0, up};
        inexact  = g | r | st;
        // With unbounded exponent, a value just under 2^-126 whose 24-bit rounding carries is not tiny
        tiny     = tiny_pre && !((e == 12'sd0) && (&norm[47:23]));
        if (tiny_pre)
            ef = {11'd0, rnd[23]};
        else
            ef = e + $signed({11'd0, rnd[24]});
        ovf      = !tiny_pre && (ef >= 12'sd255);
        res      = {s1_q.sign, ef[7:0], rnd[22:0]};
        flags    = {2'b00, tiny & inexact, inexact};
        if (ovf) begin
            res   = {s1_q.sign, 8'hff, 23'd0};
            flags = 4'b0101;
        end
        case (s1_q.cls)
            CLS_NAN: begin
                res   = 32'h7fc00000;
                flags = {s1_q.inv, 3'b000};
            end
            CLS_INF: begin
                res   = {s1_q.sign, 8'hff, 23'd0};
                flags = 4'b0000;
            end
            CLS_ZERO: begin
                res   = {s1_q.sign, 31'd0};
                flags = 4'b0000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= '0;
            {flag_invalid, flag_overflow, flag_underflow, flag_inexact} <= 4'b0000;
        end else if (vld_pipe[LATENCY-1]) begin
            out <= res;
            {flag_invalid, flag_overflow, flag_underflow, flag_inexact} <= flags;
        end
    end

    assign out_valid = vld_pipe[LATENCY];

endmodule

// File: tb/tb_fp32_mul.sv
// Bench for fp32_mul: vector table driven back-to-back into a scoreboard queue,
// plus bubble, hold and mid-flight reset sequences.
module tb_fp32_mul;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in1, in2;
    logic [31:0] out;
    logic        out_valid;
    logic        flag_invalid, flag_overflow, flag_underflow, flag_inexact;

    fp32_mul #(.LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2),
        .out(out), .out_valid(out_valid), .flag_invalid(flag_invalid),
        .flag_overflow(flag_overflow), .flag_underflow(flag_underflow),
        .flag_inexact(flag_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] a, b, y;
        logic [3:0]  f;      // {invalid, overflow, underflow, inexact}
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] y;
        logic [3:0]  f;
        int          due;
    } exp_t;

    localparam int NV = 18;
    vec_t vecs[NV];
    exp_t sbq[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    wire [3:0] flags = {flag_invalid, flag_overflow, flag_underflow, flag_inexact};

    // Scoreboard: a result must appear exactly on its due cycle, with the expected value
    always @(negedge clk) begin
        exp_t x;
        if (out_valid) begin
            checks++;
            if (sbq.size() == 0 || sbq[0].due != cyc) begin
                errors++;
                $display("FAIL unexpected_valid cyc=%0d out=%h flags=%b", cyc, out, flags);
            end else begin
                x = sbq.pop_front();
                if (out !== x.y || flags !== x.f) begin
                    errors++;
                    $display("FAIL %s: got out=%h flags=%b, want out=%h flags=%b",
                             x.nm, out, flags, x.y, x.f);
                end
            end
        end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            checks++;
            errors++;
            x = sbq.pop_front();
            $display("FAIL %s: missing out_valid at cyc=%0d", x.nm, cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic drive(input int i);
        exp_t x;
        in_valid = 1'b1;
        in1      = vecs[i].a;
        in2      = vecs[i].b;
        x.nm     = vecs[i].nm;
        x.y      = vecs[i].y;
        x.f      = vecs[i].f;
        x.due    = cyc + 3;
        sbq.push_back(x);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{"two_x_one",     32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000};
        vecs[1]  = '{"two_x_two",     32'h40000000, 32'h40000000, 32'h40800000, 4'b0000};
        vecs[2]  = '{"5p25_x_two",    32'h40A80000, 32'h40000000, 32'h41280000, 4'b0000};
        vecs[3]  = '{"inf_x_zero",    32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
        vecs[4]  = '{"zero_x_inf",    32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000};
        vecs[5]  = '{"ninf_x_two",    32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
        vecs[6]  = '{"inf_x_inf",     32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b0000};
        vecs[7]  = '{"nzero_x_three", 32'h80000000, 32'h40400000, 32'h80000000, 4'b0000};
        vecs[8]  = '{"snan_x_one",    32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000};
        vecs[9]  = '{"qnan_x_one",    32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000};
        vecs[10] = '{"overflow",      32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101};
        vecs[11] = '{"minnorm_x_half",32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000};
        vecs[12] = '{"sub1_x_half",   32'h00000001, 32'h3F000000, 32'h00000000, 4'b0011};
        vecs[13] = '{"sub3_x_half",   32'h00000003, 32'h3F000000, 32'h00000002, 4'b0011};
        vecs[14] = '{"round_inexact", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
        vecs[15] = '{"neg_two_x_3",   32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000};
        vecs[16] = '{"one_x_one",     32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000};
        vecs[17] = '{"round_to_min",  32'h007FFFFF, 32'h3F800001, 32'h00800000, 4'b0001};

        rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_out",   out, 32'h0);
        chk("reset_valid", {31'd0, out_valid}, 32'h0);
        chk("reset_flags", {28'd0, flags}, 32'h0);
        rst_n = 1'b1;

        // Back-to-back stream of every vector
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Output holds the last result while idle
        chk("hold_out",   out, vecs[NV-1].y);
        chk("hold_valid", {31'd0, out_valid}, 32'h0);

        // Bubble between two operations must reappear as a one-cycle gap
        @(negedge clk); drive(1);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); drive(2);
        @(negedge clk); in_valid = 1'b0;
        drain();

        // Reset one edge after an operation is accepted discards it
        @(negedge clk);
        in_valid = 1'b1; in1 = 32'h40000000; in2 = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out1",   out, 32'h0);
        chk("midrst_valid1", {31'd0, out_valid}, 32'h0);
        @(negedge clk);
        chk("midrst_out2",   out, 32'h0);
        chk("midrst_valid2", {31'd0, out_valid}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Pipeline is usable again after reset
        @(negedge clk); drive(2);
        @(negedge clk); in_valid = 1'b0;
        drain();

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
